// File: rtl/ef_apb_pkg.sv
// Shared types and constants for the EF APB3 initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ef_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam logic RSP_OK      = 1'b0;
    localparam logic RSP_TIMEOUT = 1'b1;

    localparam int TIMEOUT_DFLT = 255;

endpackage

// File: rtl/ef_apb_wait_timer.sv
// Wait-state counter; expired flags the PREADY=0 cycle that brings the count to LIMIT.
// Latency: expired is combinational from the current count and en.
// Backpressure: none; clr has priority over en.
module ef_apb_wait_timer #(
    parameter int CNT_W = 8,
    parameter int LIMIT = 255
) (
    input  logic core_clk,
    input  logic arst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // cnt holds the stalls already seen; this cycle is stall number cnt+1.
    assign expired = (LIMIT != 0) && en && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/ef_apb_master.sv
// APB3 initiator: one valid/ready command becomes one APB transfer plus one response.
// Latency: response 3 cycles after acceptance with zero wait states, +1 per wait state.
// Backpressure: cmd_ready stays low while a transfer runs or a response is unconsumed.
module ef_apb_master
    import ef_apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DFLT,
    parameter int CNT_W   = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    apb_state_t state;
    logic       cnt_clr;
    logic       cnt_en;
    logic       expired;

    assign cmd_ready = (state == IDLE) && !rsp_valid;

    // Only genuine ACCESS-phase stalls count toward the timeout.
    assign cnt_en  = (state == ACCESS) && PENABLE && !PREADY;
    assign cnt_clr = (state != ACCESS) || (PENABLE && PREADY) || expired;

    ef_apb_wait_timer #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .core_clk (PCLK),
        .arst_n   (PRESETn),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .expired  (expired)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= RSP_OK;
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        PADDR  <= cmd_addr;
                        PWDATA <= cmd_wdata;
                        PWRITE <= cmd_write;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PSEL    <= 1'b1;
                    PENABLE <= 1'b0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // First ACCESS cycle drives the bus setup phase; PREADY is
                    // only meaningful once PENABLE is on the wire.
                    if (!PENABLE) begin
                        PENABLE <= 1'b1;
                    end else if (PREADY) begin
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= RSP_OK;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= IDLE;
                    end else if (expired) begin
                        rsp_rdata <= '0;
                        rsp_err   <= RSP_TIMEOUT;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ef_apb_master.sv
// Directed and randomized bench for ef_apb_master against a wait-state slave model.
// Latency: n/a.
// Backpressure: rsp_ready is held low for chosen spans to exercise response stalls.
module tb_ef_apb_master;

    localparam int TMO = 4;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_acc = 0;
    int          acc_n = 0;
    int          acc_cycles = 0;
    int          slv_wait = 0;
    logic [31:0] slv_rdata = '0;

    ef_apb_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TMO),
        .CNT_W   (8)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Slave: answers after slv_wait stalled ACCESS cycles; garbage data while stalled.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            PREADY = (acc_n >= slv_wait);
            PRDATA = PREADY ? slv_rdata : $urandom;
            acc_n++;
            acc_cycles++;
        end else begin
            PREADY = 1'b0;
            PRDATA = $urandom;
            acc_n  = 0;
        end
        if (PENABLE) chk("penable_without_psel", 32'(PSEL), 32'd1);
    end

    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rd, input int wt, input int hold, input int gap);
        int          n;
        int          lat;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rd;
        exp_err = (TMO != 0) && (wt >= TMO);
        exp_lat = exp_err ? 2 + TMO : 3 + wt;
        exp_rd  = (exp_err || w) ? 32'h0 : rd;
        slv_wait  = wt;
        slv_rdata = rd;
        rsp_ready = (hold == 0);
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        chk("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        @(posedge PCLK);
        #1;
        if (gap >= 0) chk("accept_spacing", cyc - last_acc, gap);
        last_acc   = cyc;
        cmd_valid  = 1'b0;
        acc_cycles = 0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge PCLK);
            #1;
            lat++;
            if (lat == 1) begin
                chk("setup_psel", 32'(PSEL), 32'd1);
                chk("setup_penable", 32'(PENABLE), 32'd0);
            end
            if (lat == 2) chk("access_penable", 32'(PENABLE), 32'd1);
            if (PSEL) begin
                chk("paddr", PADDR, a);
                chk("pwrite", 32'(PWRITE), 32'(w));
                chk("pwdata", PWDATA, d);
            end
        end
        chk("rsp_latency", lat, exp_lat);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("access_cycles", acc_cycles, exp_err ? TMO : wt + 1);
        chk("psel_after_end", 32'(PSEL), 32'd0);
        chk("paddr_kept", PADDR, a);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge PCLK);
                #1;
                chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("hold_rsp_rdata", rsp_rdata, exp_rd);
                chk("hold_rsp_err", 32'(rsp_err), 32'(exp_err));
                chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge PCLK);
        #1;
        chk("rsp_consumed", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1;
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;

        run_cmd(1'b1, 32'h4, 32'hA5, 32'h0, 0, 0, -1);
        run_cmd(1'b0, 32'h8, 32'h0, 32'h5A, 2, 0, -1);
        run_cmd(1'b0, 32'h10, 32'h0, 32'h1234, 1000, 0, -1);
        run_cmd(1'b0, 32'h10, 32'h0, 32'h77, 0, 0, -1);
        run_cmd(1'b0, 32'h14, 32'h0, 32'hC0DE, TMO - 1, 0, -1);
        run_cmd(1'b1, 32'h18, 32'h99, 32'h0, TMO, 0, -1);
        run_cmd(1'b0, 32'h20, 32'h0, 32'hBEEF, 1, 10, -1);

        // With rsp_ready high, accepts land 5 edges apart (PSEL idle for 3 cycles).
        for (int i = 0; i < 4; i++)
            run_cmd(1'b1, 32'(i * 4), 32'h100 + 32'(i), 32'h0, 0, 0, (i == 0) ? -1 : 5);

        slv_wait = 1000;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h40;
        n = 0;
        while (!PENABLE && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        cmd_valid = 1'b0;
        chk("pre_reset_penable", 32'(PENABLE), 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        chk("async_rst_psel", 32'(PSEL), 32'd0);
        chk("async_rst_penable", 32'(PENABLE), 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        run_cmd(1'b0, 32'h44, 32'h0, 32'h5555, 0, 0, -1);

        for (int i = 0; i < 24; i++)
            run_cmd(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 2)), -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
